// File: rtl/vec_collector.sv
// Purpose : gathers a serial word stream into one packed INPUTS_NUM-slot vector for the adder tree.
// Latency : m_valid rises the cycle after the closing input handshake; next word accepted the cycle after m_ready.
// Backpr. : s_ready is low for the whole HOLD state; the vector is held stable until m_ready is seen.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   s_data/s_valid/
//   s_last/s_ready      input word stream; s_last closes a short frame
//   m_vec               packed vector, slot k at [k*IDATA_WIDTH +: IDATA_WIDTH]
//   m_count             number of slots written in the presented frame
//   m_valid/m_ready     output handshake
//   m_sum               (only with VEC_COLLECT_SUM_EN) running sum of the frame's words
//
// Optional feature macro: VEC_COLLECT_SUM_EN adds the m_sum accumulator and port.
module vec_collector #(
  parameter  int INPUTS_NUM  = 6,
  parameter  int IDATA_WIDTH = 32,
  localparam int CNT_WIDTH   = $clog2(INPUTS_NUM + 1),
  localparam int SUM_WIDTH   = IDATA_WIDTH + $clog2(INPUTS_NUM)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [IDATA_WIDTH-1:0]            s_data,
  input  logic                              s_valid,
  input  logic                              s_last,
  output logic                              s_ready,
  output logic [INPUTS_NUM*IDATA_WIDTH-1:0] m_vec,
  output logic [CNT_WIDTH-1:0]              m_count,
  output logic                              m_valid,
`ifdef VEC_COLLECT_SUM_EN
  output logic [SUM_WIDTH-1:0]              m_sum,
`endif
  input  logic                              m_ready
);

  typedef enum logic {
    S_FILL = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t                            state_q, state_d;
  logic [CNT_WIDTH-1:0]              idx_q, idx_d;
  logic [CNT_WIDTH-1:0]              count_q, count_d;
  logic [INPUTS_NUM*IDATA_WIDTH-1:0] vec_q, vec_d;

  logic in_hs;
  logic in_close;
  logic out_hs;

  assign in_hs    = s_valid & s_ready;
  // s_last on the final slot closes the frame exactly like a full vector.
  assign in_close = (idx_q == CNT_WIDTH'(INPUTS_NUM - 1)) | s_last;
  assign out_hs   = m_valid & m_ready;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FILL: if (in_hs && in_close) state_d = S_HOLD;
      S_HOLD: if (m_ready)           state_d = S_FILL;
      default: state_d = S_FILL;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // m_valid is a pure decode of the state register, so it is glitch-free
  // and rises exactly one cycle after the closing handshake.
  always_comb begin
    s_ready = (state_q == S_FILL) && !rst;
    m_valid = (state_q == S_HOLD);
  end

  // ---------------- Datapath ----------------
  // Slots are cleared on the output handshake, so unwritten slots of a short
  // frame are already zero when the next frame is presented.
  always_comb begin
    vec_d   = vec_q;
    idx_d   = idx_q;
    count_d = count_q;
    if (in_hs) begin
      for (int k = 0; k < INPUTS_NUM; k++) begin
        if (idx_q == CNT_WIDTH'(k)) begin
          vec_d[k*IDATA_WIDTH +: IDATA_WIDTH] = s_data;
        end
      end
      idx_d = idx_q + CNT_WIDTH'(1);
      if (in_close) begin
        count_d = idx_q + CNT_WIDTH'(1);
      end
    end else if (out_hs) begin
      vec_d   = '0;
      idx_d   = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vec_q   <= '0;
      idx_q   <= '0;
      count_q <= '0;
    end else begin
      vec_q   <= vec_d;
      idx_q   <= idx_d;
      count_q <= count_d;
    end
  end

  assign m_vec   = vec_q;
  assign m_count = count_q;

`ifdef VEC_COLLECT_SUM_EN
  // Accumulates alongside the slot writes, so it is ready the same cycle as m_vec.
  logic [SUM_WIDTH-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (in_hs) begin
      sum_d = sum_q + SUM_WIDTH'(s_data);
    end else if (out_hs) begin
      sum_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign m_sum = sum_q;
`endif

endmodule

// File: tb/tb_vec_collector.sv
// Bench for vec_collector with INPUTS_NUM=6, IDATA_WIDTH=32.
// Inputs are driven on the falling edge, outputs sampled on the falling edge.
module tb_vec_collector;
  localparam int N  = 6;
  localparam int W  = 32;
  localparam int CW = 3;
  localparam int SW = 35;

  logic           clk;
  logic           rst;
  logic [W-1:0]   s_data;
  logic           s_valid;
  logic           s_last;
  logic           s_ready;
  logic [N*W-1:0] m_vec;
  logic [CW-1:0]  m_count;
  logic           m_valid;
  logic           m_ready;
`ifdef VEC_COLLECT_SUM_EN
  logic [SW-1:0]  m_sum;
`endif

  vec_collector #(.INPUTS_NUM(N), .IDATA_WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_last  (s_last),
    .s_ready (s_ready),
    .m_vec   (m_vec),
    .m_count (m_count),
    .m_valid (m_valid),
`ifdef VEC_COLLECT_SUM_EN
    .m_sum   (m_sum),
`endif
    .m_ready (m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef logic [N-1:0][W-1:0] slots_t;

  typedef struct {
    slots_t        w;
    int            n;
    bit            last;
    int            gap;
    slots_t        exp_vec;
    int            exp_count;
    logic [SW-1:0] exp_sum;
  } vec_t;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Called at a falling edge; waits (bounded) until the collector is ready.
  task automatic wait_ready(input string name);
    int t = 0;
    while (!s_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check(name, {{(N*W-1){1'b0}}, s_ready}, 1);
  endtask

  // Sends n words; returns at the falling edge just after the last handshake.
  task automatic send_frame(input slots_t w, input int n, input bit last, input int gap);
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        repeat (gap) @(negedge clk);
      end
      wait_ready("s_ready_wait");
      s_valid = 1'b1;
      s_data  = w[i];
      s_last  = last && (i == n - 1);
      @(negedge clk);
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_data  = 32'h5A5A_5A5A;
    end
  endtask

  vec_t   vt[6];
  slots_t bp_w;
  slots_t rs_w;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Frame table: inputs and hand-computed expected outputs.
    vt[0].w = {32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
    vt[0].n = 6; vt[0].last = 1'b0; vt[0].gap = 0;
    vt[0].exp_vec = {32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
    vt[0].exp_count = 6; vt[0].exp_sum = 35'd21;

    vt[1].w = {32'd0, 32'd0, 32'd0, 32'd0, 32'hB, 32'hA};
    vt[1].n = 2; vt[1].last = 1'b1; vt[1].gap = 0;
    vt[1].exp_vec = {32'd0, 32'd0, 32'd0, 32'd0, 32'hB, 32'hA};
    vt[1].exp_count = 2; vt[1].exp_sum = 35'h15;

    vt[2].w = {6{32'hFFFF_FFFF}};
    vt[2].n = 6; vt[2].last = 1'b0; vt[2].gap = 3;
    vt[2].exp_vec = {6{32'hFFFF_FFFF}};
    vt[2].exp_count = 6; vt[2].exp_sum = 35'h5_FFFF_FFFA;

    vt[3].w = {32'd15, 32'd14, 32'd13, 32'd12, 32'd11, 32'd10};
    vt[3].n = 6; vt[3].last = 1'b1; vt[3].gap = 0;
    vt[3].exp_vec = {32'd15, 32'd14, 32'd13, 32'd12, 32'd11, 32'd10};
    vt[3].exp_count = 6; vt[3].exp_sum = 35'd75;

    vt[4].w = {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'h1234};
    vt[4].n = 1; vt[4].last = 1'b1; vt[4].gap = 0;
    vt[4].exp_vec = {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'h1234};
    vt[4].exp_count = 1; vt[4].exp_sum = 35'h1234;

    vt[5].w = {32'd0, 32'd0, 32'd0, 32'h30, 32'h20, 32'h10};
    vt[5].n = 3; vt[5].last = 1'b1; vt[5].gap = 1;
    vt[5].exp_vec = {32'd0, 32'd0, 32'd0, 32'h30, 32'h20, 32'h10};
    vt[5].exp_count = 3; vt[5].exp_sum = 35'h60;

    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    m_ready = 1'b1;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_vec",   m_vec,   0);
    check("rst_m_count", m_count, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_s_ready", s_ready, 1);

    // Table-driven frames, m_ready held high (back-to-back frames).
    for (int i = 0; i < 6; i++) begin
      send_frame(vt[i].w, vt[i].n, vt[i].last, vt[i].gap);
      check($sformatf("frame%0d_m_valid", i), m_valid, 1);
      check($sformatf("frame%0d_s_ready", i), s_ready, 0);
      check($sformatf("frame%0d_m_vec", i),   m_vec,   vt[i].exp_vec);
      check($sformatf("frame%0d_m_count", i), m_count, vt[i].exp_count);
`ifdef VEC_COLLECT_SUM_EN
      check($sformatf("frame%0d_m_sum", i),   m_sum,   vt[i].exp_sum);
`endif
      @(negedge clk);
      check($sformatf("frame%0d_rel_m_valid", i), m_valid, 0);
      check($sformatf("frame%0d_rel_s_ready", i), s_ready, 1);
    end

    // Backpressure: hold for 10 cycles while a word is offered with s_ready low.
    bp_w = {32'h105, 32'h104, 32'h103, 32'h102, 32'h101, 32'h100};
    m_ready = 1'b0;
    send_frame(bp_w, 6, 1'b0, 0);
    check("bp_m_valid", m_valid, 1);
    check("bp_m_vec",   m_vec,   bp_w);
    for (int c = 0; c < 10; c++) begin
      s_valid = 1'b1;
      s_data  = 32'hDEAD_0000 + c;
      s_last  = 1'b1;
      @(negedge clk);
      check($sformatf("bp_hold%0d_m_valid", c), m_valid, 1);
      check($sformatf("bp_hold%0d_m_vec", c),   m_vec,   bp_w);
      check($sformatf("bp_hold%0d_m_count", c), m_count, 6);
      check($sformatf("bp_hold%0d_s_ready", c), s_ready, 0);
    end
`ifdef VEC_COLLECT_SUM_EN
    check("bp_m_sum", m_sum, 35'h60F);
`endif
    s_valid = 1'b0;
    s_last  = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    check("bp_rel_m_valid", m_valid, 0);
    check("bp_rel_s_ready", s_ready, 1);
    check("bp_rel_m_vec",   m_vec,   0);
    check("bp_rel_m_count", m_count, 0);
    // m_ready low and no input: nothing should move.
    @(negedge clk);
    check("idle_m_valid", m_valid, 0);
    check("idle_s_ready", s_ready, 1);
    m_ready = 1'b1;

    // Reset mid-frame: partial frame must be discarded.
    rs_w = {32'd0, 32'd0, 32'd0, 32'd3, 32'd2, 32'd1};
    send_frame(rs_w, 3, 1'b0, 0);
    check("mid_m_valid", m_valid, 0);
    rst = 1'b1;
    #1;
    check("mid_rst_s_ready", s_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_m_vec",   m_vec,   0);
    check("mid_rst_m_count", m_count, 0);
    check("mid_rst_m_valid", m_valid, 0);
    rs_w = {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd7};
    send_frame(rs_w, 1, 1'b1, 0);
    check("after_rst_m_valid", m_valid, 1);
    check("after_rst_m_count", m_count, 1);
    check("after_rst_m_vec",   m_vec,   rs_w);
`ifdef VEC_COLLECT_SUM_EN
    check("after_rst_m_sum",   m_sum,   35'd7);
`endif
    @(negedge clk);
    check("after_rst_rel_m_valid", m_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
